pkt_distributor_nport: RTL



---
 rtl/pkt_defs.sv | 34 +++
 rtl/pkt_distributor_nport_serializer.sv | 102 ++++++++++
 rtl/pkt_distributor_nport.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pkt_defs.sv
// Shared packet-bridge definitions.
// Holds the per-byte / per-word packet codes used by every block on the
// packet path, the distributor state type, and small helper functions.
package pkt_defs;

    // Packet codes, shared by word-level and byte-level interfaces.
    typedef enum logic [1:0] {
        PCC_DATA   = 2'b00,
        PCC_SOP    = 2'b01,
        PCC_EOP    = 2'b10,
        PCC_BADEOP = 2'b11
    } pcc_t;

    // Distributor control state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PKT  = 2'b01,
        ST_DROP = 2'b10
    } dist_state_t;

    // EOP and BADEOP both terminate a packet; they share code bit 1.
    function automatic logic pcc_is_end(input logic [1:0] code);
        return code[1];
    endfunction

    // Saturating 8-bit increment.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic inc);
        if (inc && (v != 8'hFF)) begin
            return v + 8'd1;
        end
        return v;
    endfunction

endpackage

// File: rtl/pkt_distributor_nport_serializer.sv
// pkt_word_serializer
// Holds one accepted packet word and walks it out one byte per transfer,
// byte 0 first, producing the per-byte packet code.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   load_i          capture word_*_i into the hold register (starts at byte 0)
//   word_data_i     WORDS bytes, byte 0 in [7:0]
//   word_code_i     word packet code
//   word_cnt_i      valid bytes minus 1 (used on EOP/BADEOP words only)
//   xfer_i          current byte is consumed this cycle
//   valid_o         hold register contains a word
//   last_o          current byte is the last one of the held word
//   byte_data_o     current byte
//   byte_code_o     code for the current byte
//   held_code_o     code of the held word
module pkt_word_serializer
    import pkt_defs::*;
#(
    parameter int WORDS = 4,
    parameter int CW    = $clog2(WORDS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic [WORDS*8-1:0] word_data_i,
    input  logic [1:0]         word_code_i,
    input  logic [CW-1:0]      word_cnt_i,
    input  logic               xfer_i,
    output logic               valid_o,
    output logic               last_o,
    output logic [7:0]         byte_data_o,
    output logic [1:0]         byte_code_o,
    output logic [1:0]         held_code_o
);

    logic [WORDS-1:0][7:0] data_q;
    logic [1:0]            code_q;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         idx_q, idx_d;
    logic                  valid_q, valid_d;
    logic [CW-1:0]         last_idx;

    // Short words end at cnt; the clamp keeps a stray cnt inside the word
    // when WORDS is not a power of two.
    always_comb begin
        last_idx = CW'(WORDS - 1);
        if (pcc_is_end(code_q) && (cnt_q < CW'(WORDS - 1))) begin
            last_idx = cnt_q;
        end
    end

    assign last_o      = (idx_q == last_idx);
    assign valid_o     = valid_q;
    assign byte_data_o = data_q[idx_q];
    assign held_code_o = code_q;

    always_comb begin
        byte_code_o = PCC_DATA;
        if ((idx_q == '0) && (code_q == PCC_SOP)) begin
            byte_code_o = PCC_SOP;
        end else if (last_o && pcc_is_end(code_q)) begin
            byte_code_o = code_q;
        end
    end

    // A load wins over the finishing transfer: that is how the next word
    // follows the last byte of the previous one without a bubble.
    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        if (load_i) begin
            valid_d = 1'b1;
            idx_d   = '0;
        end else if (xfer_i) begin
            if (last_o) begin
                valid_d = 1'b0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
        end
    end

    // Payload fields carry no reset; they are qualified by valid_q.
    always_ff @(posedge clk) begin
        if (load_i) begin
            data_q <= word_data_i;
            code_q <= word_code_i;
            cnt_q  <= word_cnt_i;
        end
    end

endmodule

// File: rtl/pkt_distributor_nport.sv
// pkt_distributor_nport
// Takes packet-FIFO words (WORDS bytes each) and serialises them into a byte
// stream steered to one of NPORTS channels, selected by the destination on
// the SOP word. Malformed or misaddressed traffic is consumed and counted.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   ptx_srdy/ptx_drdy   input word handshake
//   ptx_data            word payload, byte 0 in [7:0] sent first
//   ptx_code            word code (DATA/SOP/EOP/BADEOP)
//   ptx_cnt             valid bytes minus 1 on EOP/BADEOP words
//   ptx_dest            destination channel, sampled on SOP words
//   p_srdy/p_drdy       per-channel byte handshake (p_srdy one-hot)
//   p_code, p_data      byte code and byte, shared across channels
//   err_cnt             saturating protocol-error count
module pkt_distributor_nport
    import pkt_defs::*;
#(
    parameter int WORDS  = 4,
    parameter int NPORTS = 4,
    parameter int CW     = $clog2(WORDS),
    parameter int DW     = $clog2(NPORTS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ptx_srdy,
    output logic               ptx_drdy,
    input  logic [WORDS*8-1:0] ptx_data,
    input  logic [1:0]         ptx_code,
    input  logic [CW-1:0]      ptx_cnt,
    input  logic [DW-1:0]      ptx_dest,
    output logic [NPORTS-1:0]  p_srdy,
    input  logic [NPORTS-1:0]  p_drdy,
    output logic [1:0]         p_code,
    output logic [7:0]         p_data,
    output logic [7:0]         err_cnt
);

    dist_state_t       state_q, state_d, eff_state;
    logic [DW-1:0]     dest_q, dest_d;
    logic [7:0]        err_q, err_d;
    logic              err_inc;
    logic              load;

    logic              ser_valid, ser_last;
    logic [7:0]        ser_byte;
    logic [1:0]        ser_bcode, ser_hcode;

    logic              sending, xfer, last_xfer, pkt_end, acc, dest_ok;
    logic [NPORTS-1:0] dest_onehot;

    pkt_word_serializer #(
        .WORDS (WORDS),
        .CW    (CW)
    ) u_ser (
        .clk         (clk),
        .reset       (reset),
        .load_i      (load),
        .word_data_i (ptx_data),
        .word_code_i (ptx_code),
        .word_cnt_i  (ptx_cnt),
        .xfer_i      (xfer),
        .valid_o     (ser_valid),
        .last_o      (ser_last),
        .byte_data_o (ser_byte),
        .byte_code_o (ser_bcode),
        .held_code_o (ser_hcode)
    );

    always_comb begin
        dest_onehot         = '0;
        dest_onehot[dest_q] = 1'b1;
    end

    assign sending   = ser_valid && (state_q == ST_PKT);
    assign xfer      = sending && p_drdy[dest_q];
    assign last_xfer = xfer && ser_last;
    assign ptx_drdy  = !ser_valid || last_xfer;
    assign acc       = ptx_srdy && ptx_drdy;

    // The packet closes in the same cycle its final byte leaves, so a word
    // arriving in that cycle is judged as if the block were already idle.
    assign pkt_end   = last_xfer && pcc_is_end(ser_hcode);
    assign eff_state = pkt_end ? ST_IDLE : state_q;

    assign dest_ok   = ({1'b0, ptx_dest} < (DW + 1)'(NPORTS));

    assign p_srdy    = sending ? dest_onehot : '0;
    assign p_data    = sending ? ser_byte : 8'h00;
    assign p_code    = sending ? ser_bcode : 2'b00;
    assign err_cnt   = err_q;

    // Next-state decode; only accepted words move the FSM, apart from the
    // packet close above. Dropped words never reach the hold register.
    always_comb begin
        state_d = eff_state;
        dest_d  = dest_q;
        load    = 1'b0;
        err_inc = 1'b0;
        if (acc) begin
            if (ptx_code == PCC_SOP) begin
                // An SOP inside a packet truncates it.
                if (eff_state == ST_PKT) begin
                    err_inc = 1'b1;
                end
                if (dest_ok) begin
                    state_d = ST_PKT;
                    dest_d  = ptx_dest;
                    load    = 1'b1;
                end else begin
                    state_d = ST_DROP;
                    err_inc = 1'b1;
                end
            end else begin
                case (eff_state)
                    ST_PKT: begin
                        load = 1'b1;
                    end
                    ST_DROP: begin
                        if (pcc_is_end(ptx_code)) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: begin
                        err_inc = 1'b1;
                    end
                endcase
            end
        end
    end

    assign err_d = sat_inc8(err_q, err_inc);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            dest_q  <= '0;
            err_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            err_q   <= err_d;
        end
    end

endmodule
